// File: rtl/clf_pkg.sv
// Shared types and defaults for the switch decoder and the combination-lock FSM.
package clf_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StHeld = 1'b1
    } clf_state_e;

    localparam int unsigned NUM_SW_DEF     = 8;
    localparam int unsigned KEY_W_DEF      = 3;
    localparam int unsigned SIM_DEBOUNCE   = 4;
    localparam int unsigned BOARD_DEBOUNCE = 1000000;
    localparam int unsigned CNT_W_DEF      = 20;

endpackage

// File: rtl/sw_key_decoder_if.sv
// Switch-in / key-event-out bundle between the board switches, the decoder and its consumer.
interface sw_key_decoder_if
    import clf_pkg::*;
#(
    parameter int unsigned NUM_SW = NUM_SW_DEF,
    parameter int unsigned KEY_W  = KEY_W_DEF
);

    logic [NUM_SW-1:0] sw;
    logic [NUM_SW-1:0] sw_stable;
    logic              key_valid;
    logic [KEY_W-1:0]  key_code;
    logic              key_multi;
    logic              key_held;

    modport master (
        output sw,
        input  sw_stable, key_valid, key_code, key_multi, key_held
    );

    modport slave (
        input  sw,
        output sw_stable, key_valid, key_code, key_multi, key_held
    );

endinterface

// File: rtl/sw_debounce.sv
// Single-bit two-flop synchroniser followed by a persistence counter; the stable level resets to 1.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            s1_q     <= sw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/sw_key_decoder.sv
// Debounces active-low switches and turns accepted presses into one-cycle key events,
// locking out further presses until every switch has been released.
module sw_key_decoder
    import clf_pkg::*;
#(
    parameter int unsigned NUM_SW          = NUM_SW_DEF,
    parameter int unsigned KEY_W           = KEY_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = SIM_DEBOUNCE,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    sw_key_decoder_if.slave kbd
);

    logic [NUM_SW-1:0] stable_lvl;
    logic [NUM_SW-1:0] prev_q;
    logic [NUM_SW-1:0] fall;
    logic              fall_any, fall_multi;
    logic [KEY_W-1:0]  fall_idx;

    clf_state_e        state_q;
    logic              valid_q, multi_q;
    logic [KEY_W-1:0]  code_q;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .sw_i    (kbd.sw[i]),
            .stable_o(stable_lvl[i])
        );
    end

    assign fall = prev_q & ~stable_lvl;

    // Clearing the lowest set bit leaves something only if two or more falls coincide.
    always_comb begin
        fall_any   = |fall;
        fall_multi = |(fall & (fall - NUM_SW'(1)));
        fall_idx   = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (fall[i]) begin
                fall_idx = KEY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            prev_q  <= '1;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            code_q  <= '0;
        end else begin
            prev_q  <= stable_lvl;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (fall_multi) begin
                        multi_q <= 1'b1;
                        state_q <= StHeld;
                    end else if (fall_any) begin
                        valid_q <= 1'b1;
                        code_q  <= fall_idx;
                        state_q <= StHeld;
                    end
                end
                StHeld: begin
                    if (&stable_lvl) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign kbd.sw_stable = stable_lvl;
    assign kbd.key_valid = valid_q;
    assign kbd.key_code  = code_q;
    assign kbd.key_multi = multi_q;
    assign kbd.key_held  = (state_q == StHeld);

endmodule

// File: tb/tb_sw_key_decoder.sv
// Directed plus randomized switch traffic against a behavioural key-decoder model.
module tb_sw_key_decoder;
    import clf_pkg::*;

    localparam int unsigned NSw  = NUM_SW_DEF;
    localparam int unsigned KeyW = KEY_W_DEF;
    localparam int unsigned Deb  = SIM_DEBOUNCE;

    logic clk = 1'b0;
    logic rst;

    sw_key_decoder_if #(.NUM_SW(NSw), .KEY_W(KeyW)) kbd ();

    sw_key_decoder #(
        .NUM_SW         (NSw),
        .KEY_W          (KeyW),
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (CNT_W_DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kbd(kbd)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a level is accepted once the same new value has been seen on D consecutive
    // synchronised samples; synchronised sample = raw value two edges ago.
    logic [7:0] samp_q[$];
    logic [7:0] m_stable, m_prev;
    logic       m_held, m_valid, m_multi;
    logic [2:0] m_code;

    always @(posedge clk or posedge rst) begin
        logic [7:0] fall, nxt;
        int         nfall;
        bit         all_diff;
        if (rst) begin
            samp_q.delete();
            for (int i = 0; i < Deb + 2; i++) samp_q.push_front(8'hFF);
            m_stable = 8'hFF;
            m_prev   = 8'hFF;
            m_held   = 1'b0;
            m_valid  = 1'b0;
            m_multi  = 1'b0;
            m_code   = 3'd0;
        end else begin
            fall = m_prev & ~m_stable;
            nxt  = m_stable;
            for (int b = 0; b < 8; b++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= Deb; k++) begin
                    if (samp_q[k][b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) nxt[b] = ~m_stable[b];
            end
            m_valid = 1'b0;
            m_multi = 1'b0;
            nfall   = $countones(fall);
            if (!m_held) begin
                if (nfall == 1) begin
                    m_valid = 1'b1;
                    m_held  = 1'b1;
                    for (int b = 0; b < 8; b++) if (fall[b]) m_code = 3'(b);
                end else if (nfall >= 2) begin
                    m_multi = 1'b1;
                    m_held  = 1'b1;
                end
            end else if (m_stable == 8'hFF) begin
                m_held = 1'b0;
            end
            m_prev   = m_stable;
            m_stable = nxt;
            samp_q.push_front(kbd.sw);
            void'(samp_q.pop_back());
        end
    end

    int unsigned n_valid = 0;
    int unsigned n_multi = 0;
    logic [2:0]  codes[$];

    always @(negedge clk) begin
        check_eq("sw_stable", 32'(kbd.sw_stable), 32'(m_stable));
        check_eq("key_valid", 32'(kbd.key_valid), 32'(m_valid));
        check_eq("key_multi", 32'(kbd.key_multi), 32'(m_multi));
        check_eq("key_held", 32'(kbd.key_held), 32'(m_held));
        check_eq("key_code", 32'(kbd.key_code), 32'(m_code));
        check_eq("valid_multi_excl", 32'(kbd.key_valid & kbd.key_multi), 32'd0);
        if (kbd.key_valid) begin
            n_valid++;
            codes.push_back(kbd.key_code);
        end
        if (kbd.key_multi) n_multi++;
    end

    task automatic hold(input logic [7:0] v, input int ns);
        kbd.sw = v;
        #(ns);
    endtask

    int unsigned v0, m0;
    logic [7:0]  one = 8'h01;
    logic [7:0]  rv;

    initial begin
        rst    = 1'b1;
        kbd.sw = 8'hFF;
        #32 rst = 1'b0;
        #20;
        check_eq("no_strobe_after_reset", n_valid + n_multi, 0);

        // Single press: first sampling edge at 55 ns, strobe visible on the 120 ns negedge.
        kbd.sw = 8'hFE;
        #50 kbd.sw = 8'hFF;
        #8  check_eq("lat_before", 32'(kbd.key_valid), 32'd0);
        #10 check_eq("lat_pulse", 32'(kbd.key_valid), 32'd1);
        check_eq("lat_code", 32'(kbd.key_code), 32'd0);
        #10 check_eq("lat_after", 32'(kbd.key_valid), 32'd0);
        hold(8'hFF, 72);
        check_eq("single_count", n_valid, 1);
        hold(8'hFE, 50);
        hold(8'hFF, 100);
        check_eq("repeat_count", n_valid, 2);
        check_eq("repeat_held_clear", 32'(kbd.key_held), 32'd0);

        // Code sequence.
        codes.delete();
        v0 = n_valid;
        m0 = n_multi;
        hold(8'hFE, 50); hold(8'hFF, 50); hold(8'hFE, 50); hold(8'hFF, 50);
        hold(8'hFB, 50); hold(8'hFF, 50); hold(8'hF7, 50); hold(8'hFF, 100);
        check_eq("seq_count", n_valid - v0, 4);
        check_eq("seq_multi", n_multi - m0, 0);
        if (codes.size() == 4) begin
            check_eq("seq_code0", 32'(codes[0]), 32'd0);
            check_eq("seq_code1", 32'(codes[1]), 32'd0);
            check_eq("seq_code2", 32'(codes[2]), 32'd2);
            check_eq("seq_code3", 32'(codes[3]), 32'd3);
        end

        // Glitch then genuine press on sw[5].
        v0 = n_valid;
        hold(8'hDF, 30);
        hold(8'hFF, 100);
        check_eq("glitch_reject", n_valid - v0, 0);
        hold(8'hDF, 50);
        hold(8'hFF, 100);
        check_eq("glitch_accept", n_valid - v0, 1);
        check_eq("glitch_code", 32'(kbd.key_code), 32'd5);

        // Multi press, press while held, then a fresh press.
        v0 = n_valid;
        m0 = n_multi;
        hold(8'hEE, 60);
        hold(8'h7E, 60);
        hold(8'hFF, 100);
        check_eq("multi_count", n_multi - m0, 1);
        check_eq("multi_no_valid", n_valid - v0, 0);
        hold(8'h7F, 60);
        hold(8'hFF, 100);
        check_eq("after_multi_valid", n_valid - v0, 1);
        check_eq("after_multi_code", 32'(kbd.key_code), 32'd7);

        // Reset while HELD, switch still down across reset.
        hold(8'hFD, 80);
        check_eq("pre_reset_held", 32'(kbd.key_held), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_held", 32'(kbd.key_held), 32'd0);
        check_eq("rst_stable", 32'(kbd.sw_stable), 32'hFF);
        check_eq("rst_code", 32'(kbd.key_code), 32'd0);
        #9 rst = 1'b0;
        v0 = n_valid;
        hold(8'hFD, 80);
        check_eq("rerun_valid", n_valid - v0, 1);
        check_eq("rerun_code", 32'(kbd.key_code), 32'd1);
        hold(8'hFF, 100);

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 3))
                0: rv = 8'hFF;
                1: rv = ~(one << $urandom_range(0, 7));
                2: rv = ~((one << $urandom_range(0, 7)) | (one << $urandom_range(0, 7)));
                default: rv = 8'($urandom);
            endcase
            hold(rv, 10 * int'($urandom_range(1, 8)));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #10 rst = 1'b0;
            end
        end
        hold(8'hFF, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
